piso_serializer: RTL and testbench

- Parallel-in/serial-out stage that sits directly upstream of the team's 8-bit SIPO shift register.
- Accepts WIDTH-bit words over a valid/ready handshake and emits them MSB-first, one bit per clk. A SIPO that shifts left and inserts at bit 0 therefore reassembles the original word after WIDTH edges.
- A one-word holding buffer allows gapless back-to-back frames.

---
 rtl/piso_serializer_pkg.sv | 12 +
 rtl/piso_serializer_if.sv | 25 ++
 rtl/piso_serializer.sv | 90 +++++++++
 tb/tb_piso_serializer.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the PISO serializer and its downstream SIPO stage.
package piso_serializer_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam logic DEFAULT_IDLE_BIT = 1'b0;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

endpackage

// File: rtl/piso_serializer_if.sv
// Word-in / bit-out bus of the PISO serializer; slave is the serializer side.
interface piso_serializer_if #(
  parameter int unsigned WIDTH = piso_serializer_pkg::DEFAULT_WIDTH
);

  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             sout;
  logic             sout_valid;
  logic             frame_start;
  logic             frame_end;
  logic             busy;

  modport master (
    output din, din_valid,
    input  din_ready, sout, sout_valid, frame_start, frame_end, busy
  );

  modport slave (
    input  din, din_valid,
    output din_ready, sout, sout_valid, frame_start, frame_end, busy
  );

endinterface

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage: one-word holding buffer feeding an MSB-first
// shifter, so back-to-back words leave as one contiguous bit stream.
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int unsigned WIDTH    = DEFAULT_WIDTH,
  parameter logic        IDLE_BIT = DEFAULT_IDLE_BIT
) (
  input logic              clk,
  input logic              rst,
  piso_serializer_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             holdFull_q, holdFull_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] bitCnt_q, bitCnt_d;
  logic             load;
  logic             accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      holdFull_q <= 1'b0;
      shreg_q    <= '0;
      bitCnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      holdFull_q <= holdFull_d;
      shreg_q    <= shreg_d;
      bitCnt_q   <= bitCnt_d;
    end
  end

  // Accept and load never coincide: a load needs a full buffer, which holds ready low.
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    holdFull_d = holdFull_q;
    shreg_d    = shreg_q;
    bitCnt_d   = bitCnt_q;
    load       = 1'b0;
    accept     = bus.din_valid && !holdFull_q;

    case (state_q)
      IDLE: begin
        if (holdFull_q) begin
          load = 1'b1;
        end
      end
      SHIFT: begin
        if (bitCnt_q != LAST_BIT) begin
          shreg_d  = shreg_q << 1;
          bitCnt_d = bitCnt_q + 1'b1;
        end else if (holdFull_q) begin
          load = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      shreg_d    = hold_q;
      holdFull_d = 1'b0;
      bitCnt_d   = '0;
      state_d    = SHIFT;
    end

    if (accept) begin
      hold_d     = bus.din;
      holdFull_d = 1'b1;
    end
  end

  assign bus.din_ready   = !holdFull_q;
  assign bus.sout        = (state_q == SHIFT) ? shreg_q[WIDTH-1] : IDLE_BIT;
  assign bus.sout_valid  = (state_q == SHIFT);
  assign bus.frame_start = (state_q == SHIFT) && (bitCnt_q == '0);
  assign bus.frame_end   = (state_q == SHIFT) && (bitCnt_q == LAST_BIT);
  assign bus.busy        = (state_q == SHIFT) || holdFull_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench: 8-bit and 2-bit serializers against a word-queue model
// of the expected MSB-first stream, plus a behavioural SIPO on the 8-bit output.
module tb_piso_serializer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  piso_serializer_if #(.WIDTH(8)) bus8 ();
  piso_serializer_if #(.WIDTH(2)) bus2 ();

  piso_serializer #(.WIDTH(8), .IDLE_BIT(1'b0)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  piso_serializer #(.WIDTH(2), .IDLE_BIT(1'b0)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] sipoQ;
  always @(posedge clk or posedge rst) begin
    if (rst) sipoQ <= '0;
    else     sipoQ <= {sipoQ[6:0], bus8.sout};
  end

  bit         obsBit8[$];
  bit         obsStart8[$];
  bit         obsEnd8[$];
  int         obsCyc8[$];
  int         idleErr8 = 0;
  logic [7:0] expWords8[$];

  bit         obsBit2[$];
  bit         obsStart2[$];
  bit         obsEnd2[$];
  int         obsCyc2[$];
  int         idleErr2 = 0;

  // Record every frame bit mid-cycle; anything non-idle outside a frame is an error.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus8.sout_valid) begin
        obsBit8.push_back(bus8.sout);
        obsStart8.push_back(bus8.frame_start);
        obsEnd8.push_back(bus8.frame_end);
        obsCyc8.push_back(cyc);
      end else if (bus8.sout !== 1'b0 || bus8.frame_start || bus8.frame_end) begin
        idleErr8++;
      end
      if (bus2.sout_valid) begin
        obsBit2.push_back(bus2.sout);
        obsStart2.push_back(bus2.frame_start);
        obsEnd2.push_back(bus2.frame_end);
        obsCyc2.push_back(cyc);
      end else if (bus2.sout !== 1'b0 || bus2.frame_start || bus2.frame_end) begin
        idleErr2++;
      end
    end
  end

  task automatic clear8();
    obsBit8.delete();
    obsStart8.delete();
    obsEnd8.delete();
    obsCyc8.delete();
    expWords8.delete();
    idleErr8 = 0;
  endtask

  task automatic sendWord8(input logic [7:0] w, output int accCyc);
    int  waited = 0;
    bit  done = 0;
    accCyc = -1;
    @(negedge clk);
    bus8.din       = w;
    bus8.din_valid = 1'b1;
    while (!done) begin
      if (bus8.din_ready) begin
        accCyc = cyc + 1;
        done   = 1;
      end
      @(posedge clk);
      if (!done) begin
        waited++;
        if (waited > 100) begin
          total++;
          bad++;
          $display("[TB] FAIL accept8 word %h: not accepted within %0d cycles", w, waited);
          done = 1;
        end else begin
          @(negedge clk);
        end
      end
    end
    if (accCyc >= 0) expWords8.push_back(w);
  endtask

  task automatic idle8();
    @(negedge clk);
    bus8.din_valid = 1'b0;
  endtask

  task automatic sendWord2(input logic [1:0] w);
    int waited = 0;
    bit done = 0;
    @(negedge clk);
    bus2.din       = w;
    bus2.din_valid = 1'b1;
    while (!done) begin
      if (bus2.din_ready) done = 1;
      @(posedge clk);
      if (!done) begin
        waited++;
        if (waited > 100) begin
          total++;
          bad++;
          $display("[TB] FAIL accept2 word %b: not accepted within %0d cycles", w, waited);
          done = 1;
        end else begin
          @(negedge clk);
        end
      end
    end
  endtask

  task automatic idle2();
    @(negedge clk);
    bus2.din_valid = 1'b0;
  endtask

  // Compare the observed stream with the queued words, MSB first, 8 bits per frame.
  task automatic checkStream8(input string name, input bit gapless);
    int need = expWords8.size() * 8;
    int n = 0;
    while (obsBit8.size() < need && n < need + 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    repeat (5) @(negedge clk);
    #1;
    total++;
    if (obsBit8.size() != need) begin
      bad++;
      $display("[TB] FAIL %s bitcount: got %0d bits, expected %0d", name, obsBit8.size(), need);
    end else begin
      for (int i = 0; i < expWords8.size(); i++) begin
        logic [7:0] w, s, e;
        for (int k = 0; k < 8; k++) begin
          w[7-k] = obsBit8[i*8+k];
          s[7-k] = obsStart8[i*8+k];
          e[7-k] = obsEnd8[i*8+k];
        end
        total++;
        if (w !== expWords8[i]) begin
          bad++;
          $display("[TB] FAIL %s word%0d: got %h expected %h", name, i, w, expWords8[i]);
        end
        total++;
        if (s !== 8'h80) begin
          bad++;
          $display("[TB] FAIL %s start%0d: got %b expected %b", name, i, s, 8'h80);
        end
        total++;
        if (e !== 8'h01) begin
          bad++;
          $display("[TB] FAIL %s end%0d: got %b expected %b", name, i, e, 8'h01);
        end
      end
      if (gapless && need > 0) begin
        total++;
        if (obsCyc8[need-1] - obsCyc8[0] !== need - 1) begin
          bad++;
          $display("[TB] FAIL %s gapless: span %0d cycles, expected %0d",
                   name, obsCyc8[need-1] - obsCyc8[0] + 1, need);
        end
      end
    end
    total++;
    if (idleErr8 !== 0) begin
      bad++;
      $display("[TB] FAIL %s idle: got %0d non-idle idle cycles, expected 0", name, idleErr8);
    end
  endtask

  task automatic test_reset();
    bus8.din = '0; bus8.din_valid = 1'b0;
    bus2.din = '0; bus2.din_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    total++; if (bus8.sout !== 1'b0) begin bad++; $display("[TB] FAIL reset sout: got %b expected 0", bus8.sout); end
    total++; if (bus8.sout_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset sout_valid: got %b expected 0", bus8.sout_valid); end
    total++; if (bus8.frame_start !== 1'b0) begin bad++; $display("[TB] FAIL reset frame_start: got %b expected 0", bus8.frame_start); end
    total++; if (bus8.frame_end !== 1'b0) begin bad++; $display("[TB] FAIL reset frame_end: got %b expected 0", bus8.frame_end); end
    total++; if (bus8.busy !== 1'b0) begin bad++; $display("[TB] FAIL reset busy: got %b expected 0", bus8.busy); end
    total++; if (bus8.din_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset din_ready: got %b expected 1", bus8.din_ready); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_word();
    int acc;
    clear8();
    sendWord8(8'hA5, acc);
    idle8();
    checkStream8("single", 1'b1);
    total++;
    if (obsCyc8.size() == 0 || obsCyc8[0] !== acc + 1) begin
      bad++;
      $display("[TB] FAIL single latency: first bit at cycle %0d, expected %0d",
               (obsCyc8.size() == 0) ? -1 : obsCyc8[0], acc + 1);
    end
    total++; if (bus8.busy !== 1'b0) begin bad++; $display("[TB] FAIL single busy_after: got %b expected 0", bus8.busy); end
    total++; if (bus8.sout !== 1'b0) begin bad++; $display("[TB] FAIL single sout_after: got %b expected 0", bus8.sout); end
  endtask

  task automatic test_back_to_back();
    int acc;
    clear8();
    sendWord8(8'hA5, acc);
    sendWord8(8'h3C, acc);
    idle8();
    checkStream8("back_to_back", 1'b1);
  endtask

  task automatic test_backpressure();
    int acc;
    clear8();
    sendWord8(8'hA5, acc);
    sendWord8(8'h3C, acc);
    @(negedge clk);
    #1;
    total++; if (bus8.din_ready !== 1'b0) begin bad++; $display("[TB] FAIL backpressure ready: got %b expected 0", bus8.din_ready); end
    total++; if (bus8.busy !== 1'b1) begin bad++; $display("[TB] FAIL backpressure busy: got %b expected 1", bus8.busy); end
    sendWord8(8'hFF, acc);
    idle8();
    checkStream8("backpressure", 1'b1);
  endtask

  task automatic test_reset_mid_frame();
    int acc;
    int n = 0;
    clear8();
    sendWord8(8'hF0, acc);
    sendWord8(8'h0F, acc);
    idle8();
    while (obsBit8.size() < 3 && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    rst = 1'b1;
    #1;
    total++; if (bus8.sout_valid !== 1'b0) begin bad++; $display("[TB] FAIL midreset sout_valid: got %b expected 0", bus8.sout_valid); end
    total++; if (bus8.busy !== 1'b0) begin bad++; $display("[TB] FAIL midreset busy: got %b expected 0", bus8.busy); end
    total++; if (bus8.din_ready !== 1'b1) begin bad++; $display("[TB] FAIL midreset din_ready: got %b expected 1", bus8.din_ready); end
    total++; if (bus8.sout !== 1'b0) begin bad++; $display("[TB] FAIL midreset sout: got %b expected 0", bus8.sout); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    #1;
    total++;
    if (obsBit8.size() != 3 || idleErr8 != 0) begin
      bad++;
      $display("[TB] FAIL midreset quiet: got %0d bits and %0d idle errors, expected 3 and 0",
               obsBit8.size(), idleErr8);
    end
    clear8();
    sendWord8(8'h5A, acc);
    idle8();
    checkStream8("after_reset", 1'b1);
  endtask

  task automatic test_loopback();
    int acc;
    int n = 0;
    clear8();
    sendWord8(8'hC3, acc);
    idle8();
    while (!(bus8.sout_valid && bus8.frame_end) && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    @(posedge clk);
    #1;
    total++;
    if (sipoQ !== 8'hC3) begin
      bad++;
      $display("[TB] FAIL loopback sipo: got %h expected %h", sipoQ, 8'hC3);
    end
    checkStream8("loopback", 1'b1);
  endtask

  task automatic test_random();
    int acc;
    int gap;
    clear8();
    for (int i = 0; i < 24; i++) begin
      gap = $urandom_range(0, 3);
      if (gap != 0) begin
        idle8();
        repeat (gap) @(posedge clk);
      end
      sendWord8(8'($urandom), acc);
    end
    idle8();
    checkStream8("random", 1'b0);
  endtask

  task automatic test_width2();
    int n = 0;
    bit [3:0] b, s, e;
    obsBit2.delete(); obsStart2.delete(); obsEnd2.delete(); obsCyc2.delete();
    idleErr2 = 0;
    sendWord2(2'b10);
    sendWord2(2'b01);
    idle2();
    while (obsBit2.size() < 4 && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    repeat (4) @(negedge clk);
    #1;
    total++;
    if (obsBit2.size() != 4) begin
      bad++;
      $display("[TB] FAIL width2 bitcount: got %0d bits, expected 4", obsBit2.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        b[3-k] = obsBit2[k];
        s[3-k] = obsStart2[k];
        e[3-k] = obsEnd2[k];
      end
      total++; if (b !== 4'b1001) begin bad++; $display("[TB] FAIL width2 bits: got %b expected 1001", b); end
      total++; if (s !== 4'b1010) begin bad++; $display("[TB] FAIL width2 start: got %b expected 1010", s); end
      total++; if (e !== 4'b0101) begin bad++; $display("[TB] FAIL width2 end: got %b expected 0101", e); end
      total++;
      if (obsCyc2[3] - obsCyc2[0] !== 3) begin
        bad++;
        $display("[TB] FAIL width2 gapless: span %0d cycles, expected 4", obsCyc2[3] - obsCyc2[0] + 1);
      end
    end
    total++;
    if (idleErr2 !== 0) begin
      bad++;
      $display("[TB] FAIL width2 idle: got %0d non-idle idle cycles, expected 0", idleErr2);
    end
  endtask

  initial begin
    $display("[TB] starting piso_serializer bench");
    test_reset();
    test_single_word();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_frame();
    test_loopback();
    test_random();
    test_width2();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
